// File: rtl/rotate_pipe.sv
// Pipelined funnel shifter: one 2W-bit register stage per shift-amount bit, valid/ready handshake.
// Optional zero-result flag on port Z when ROTATE_PIPE_ZERO_FLAG_EN is defined.
module rotate_pipe #(
    parameter int W  = 32,
    parameter int KW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  A,
    input  logic [W-1:0]  B,
    input  logic [KW-1:0] K,
    input  logic          right,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  F
`ifdef ROTATE_PIPE_ZERO_FLAG_EN
    ,
    output logic          Z
`endif
);

    localparam int STAGES = KW;
    localparam int WW     = 2 * W;

    logic [WW-1:0]     word_q  [STAGES];
    logic [WW-1:0]     word_d  [STAGES];
    logic [KW-1:0]     k_q     [STAGES];
    logic [KW-1:0]     k_d     [STAGES];
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] right_q, right_d;
    logic              stall;

    function automatic logic [WW-1:0] stage_shift(input logic [WW-1:0] w, input logic en,
                                                  input logic dir_r, input int amt);
        if (!en)
            return w;
        return dir_r ? (w >> amt) : (w << amt);
    endfunction

    assign stall     = valid_q[STAGES-1] && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = valid_q[STAGES-1];
    assign F         = right_q[STAGES-1] ? word_q[STAGES-1][W-1:0] : word_q[STAGES-1][WW-1:W];

    // k carries only the not-yet-applied amount bits: each stage consumes bit 0 and shifts it out.
    always_comb begin
        word_d  = word_q;
        k_d     = k_q;
        valid_d = valid_q;
        right_d = right_q;
        if (!stall) begin
            valid_d[0] = in_valid;
            right_d[0] = right;
            k_d[0]     = K >> 1;
            word_d[0]  = stage_shift({A, B}, K[0], right, 1);
            for (int i = 1; i < STAGES; i++) begin
                valid_d[i] = valid_q[i-1];
                right_d[i] = right_q[i-1];
                k_d[i]     = k_q[i-1] >> 1;
                word_d[i]  = stage_shift(word_q[i-1], k_q[i-1][0], right_q[i-1], 1 << i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            right_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                word_q[i] <= '0;
                k_q[i]    <= '0;
            end
        end else begin
            valid_q <= valid_d;
            right_q <= right_d;
            for (int i = 0; i < STAGES; i++) begin
                word_q[i] <= word_d[i];
                k_q[i]    <= k_d[i];
            end
        end
    end

`ifdef ROTATE_PIPE_ZERO_FLAG_EN
    logic [W-1:0] f_d;
    logic         z_d, z_q;

    // Flag is computed from the next last-stage word so it updates on the same edge as F.
    always_comb begin
        f_d = right_d[STAGES-1] ? word_d[STAGES-1][W-1:0] : word_d[STAGES-1][WW-1:W];
        z_d = (f_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            z_q <= 1'b0;
        else
            z_q <= z_d;
    end

    assign Z = z_q;
`endif

endmodule

// File: tb/tb_rotate_pipe.sv
// Self-checking bench for rotate_pipe (W=32): directed vectors, latency, backpressure, reset, random traffic.
module tb_rotate_pipe;

    localparam int W      = 32;
    localparam int KW     = 5;
    localparam int STAGES = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          right = 1'b0;
    logic          out_ready = 1'b1;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic [KW-1:0] K = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  F;
`ifdef ROTATE_PIPE_ZERO_FLAG_EN
    logic          Z;
`endif

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    rotate_pipe #(.W(W), .KW(KW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .K(K), .right(right),
        .out_valid(out_valid), .out_ready(out_ready), .F(F)
`ifdef ROTATE_PIPE_ZERO_FLAG_EN
        , .Z(Z)
`endif
    );

    always #5 clk = ~clk;

    // Funnel shift straight from the definition: slice of the 2W-bit concatenation after a full shift.
    function automatic logic [W-1:0] ref_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input int k, input logic r);
        logic [2*W-1:0] ab, t;
        ab = {a, b};
        if (r) begin
            t = ab >> k;
            return t[W-1:0];
        end
        t = ab << k;
        return t[2*W-1:W];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        A = 32'hDEADBEEF;
        B = 32'h01234567;
        K = 5'd3;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (F !== '0) begin errors++; $display("FAIL reset_F got=%h exp=0", F); end
`ifdef ROTATE_PIPE_ZERO_FLAG_EN
        checks++;
        if (Z !== 1'b0) begin errors++; $display("FAIL reset_Z got=%b exp=0", Z); end
`endif
        in_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        logic [W-1:0] va[8] = '{32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000,
                                32'hFFFF0000, 32'hFFFF0000, 32'h12345678, 32'h12345678};
        logic [W-1:0] vb[8] = '{32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF,
                                32'h0000FFFF, 32'h0000FFFF, 32'h12345678, 32'h12345678};
        int           vk[8] = '{1, 1, 31, 31, 0, 0, 4, 4};
        logic         vr[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [W-1:0] vf[8] = '{32'h00007FFF, 32'hFFFE0000, 32'hFFFE0000, 32'h00007FFF,
                                32'h0000FFFF, 32'hFFFF0000, 32'h81234567, 32'h23456781};
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            A = va[v]; B = vb[v]; K = KW'(vk[v]); right = vr[v];
            in_valid = 1'b1; out_ready = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL vec%0d_in_ready got=%b exp=1", v, in_ready); end
            @(negedge clk);
            in_valid = 1'b0;
            for (int j = 0; j < STAGES; j++) begin
                checks++;
                if (out_valid !== (j == STAGES - 1)) begin
                    errors++;
                    $display("FAIL vec%0d_latency cycle=%0d out_valid got=%b exp=%b", v, j, out_valid, j == STAGES - 1);
                end
                if (j < STAGES - 1) @(negedge clk);
            end
            checks++;
            if (F !== vf[v]) begin errors++; $display("FAIL vec%0d_F got=%h exp=%h", v, F, vf[v]); end
`ifdef ROTATE_PIPE_ZERO_FLAG_EN
            checks++;
            if (Z !== (vf[v] == '0)) begin errors++; $display("FAIL vec%0d_Z got=%b exp=%b", v, Z, vf[v] == '0); end
`endif
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] oa[6], ob[6];
        int           ok[6];
        logic         orr[6];
        int           sent = 0, got = 0, cyc = 0, stalls = 0;
        logic         prev_stall = 1'b0, stall_now;
        logic [W-1:0] prev_f = '0, e;
        for (int i = 0; i < 6; i++) begin
            oa[i] = $urandom; ob[i] = $urandom; ok[i] = $urandom_range(0, W - 1); orr[i] = 1'($urandom);
        end
        exp_q.delete();
        while ((sent < 6 || exp_q.size() > 0) && cyc < 200) begin
            @(negedge clk);
            in_valid = (sent < 6);
            if (sent < 6) begin A = oa[sent]; B = ob[sent]; K = KW'(ok[sent]); right = orr[sent]; end
            out_ready = !(cyc >= 5 && cyc < 8);
            #1;
            stall_now = out_valid && !out_ready;
            if (stall_now) begin
                stalls++;
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_in_ready cyc=%0d got=%b exp=0", cyc, in_ready); end
            end
            if (prev_stall) begin
                checks++;
                if (F !== prev_f) begin errors++; $display("FAIL b2b_F_stable cyc=%0d got=%h exp=%h", cyc, F, prev_f); end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_spurious cyc=%0d got=%h exp=none", cyc, F);
                end else begin
                    e = exp_q.pop_front();
                    got++;
                    if (F !== e) begin errors++; $display("FAIL b2b_F cyc=%0d got=%h exp=%h", cyc, F, e); end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_f(A, B, int'(K), right));
                sent++;
            end
            prev_stall = stall_now;
            prev_f = F;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != 6) begin errors++; $display("FAIL b2b_delivered got=%0d exp=6", got); end
        checks++;
        if (stalls != 3) begin errors++; $display("FAIL b2b_stall_cycles got=%0d exp=3", stalls); end
    endtask

    task automatic test_reset_flight();
        logic [W-1:0] e;
        int seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            A = $urandom; B = $urandom; K = KW'($urandom_range(1, W - 1)); right = 1'($urandom);
            in_valid = 1'b1; out_ready = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL flight_pre_reset_valid got=%b exp=1", out_valid); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flight_reset_valid got=%b exp=0", out_valid); end
        checks++;
        if (F !== '0) begin errors++; $display("FAIL flight_reset_F got=%h exp=0", F); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL flight_reset_in_ready got=%b exp=1", in_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL flight_ghost_results got=%0d exp=0", seen); end
        A = $urandom; B = $urandom; K = KW'($urandom_range(0, W - 1)); right = 1'($urandom);
        e = ref_f(A, B, int'(K), right);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int j = 0; j < STAGES; j++) begin
            checks++;
            if (out_valid !== (j == STAGES - 1)) begin
                errors++;
                $display("FAIL flight_new_latency cycle=%0d out_valid got=%b exp=%b", j, out_valid, j == STAGES - 1);
            end
            if (j < STAGES - 1) @(negedge clk);
        end
        checks++;
        if (F !== e) begin errors++; $display("FAIL flight_new_F got=%h exp=%h", F, e); end
        @(negedge clk);
    endtask

    task automatic test_random();
        int           sent = 0, got = 0, cyc = 0;
        logic         prev_stall = 1'b0, stall_now;
        logic [W-1:0] prev_f = '0, e;
        exp_q.delete();
        while ((sent < 40 || exp_q.size() > 0) && cyc < 2000) begin
            @(negedge clk);
            in_valid = (sent < 40) && ($urandom_range(0, 9) < 7);
            A = $urandom;
            B = ($urandom_range(0, 3) == 0) ? A : $urandom;
            K = KW'($urandom_range(0, W - 1));
            if ($urandom_range(0, 7) == 0) begin A = '0; B = '0; end
            right = 1'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
            #1;
            stall_now = out_valid && !out_ready;
            checks++;
            if (in_ready !== !stall_now) begin errors++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, !stall_now); end
            if (prev_stall) begin
                checks++;
                if (F !== prev_f) begin errors++; $display("FAIL rnd_F_stable cyc=%0d got=%h exp=%h", cyc, F, prev_f); end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rnd_spurious cyc=%0d got=%h exp=none", cyc, F);
                end else begin
                    e = exp_q.pop_front();
                    got++;
                    if (F !== e) begin errors++; $display("FAIL rnd_F cyc=%0d got=%h exp=%h", cyc, F, e); end
`ifdef ROTATE_PIPE_ZERO_FLAG_EN
                    checks++;
                    if (Z !== (e == '0)) begin errors++; $display("FAIL rnd_Z cyc=%0d got=%b exp=%b", cyc, Z, e == '0); end
`endif
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_f(A, B, int'(K), right));
                sent++;
            end
            prev_stall = stall_now;
            prev_f = F;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != 40) begin errors++; $display("FAIL rnd_delivered got=%0d exp=40", got); end
    endtask

`ifdef ROTATE_PIPE_ZERO_FLAG_EN
    task automatic test_zero_flag();
        logic [W-1:0] za[2] = '{32'h00000000, 32'h00000001};
        int           zk[2] = '{7, 0};
        logic         zz[2] = '{1'b1, 1'b0};
        for (int v = 0; v < 2; v++) begin
            @(negedge clk);
            A = za[v]; B = za[v]; K = KW'(zk[v]); right = 1'b1;
            in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            repeat (STAGES - 1) @(negedge clk);
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL zf%0d_valid got=%b exp=1", v, out_valid); end
            checks++;
            if (F !== za[v]) begin errors++; $display("FAIL zf%0d_F got=%h exp=%h", v, F, za[v]); end
            checks++;
            if (Z !== zz[v]) begin errors++; $display("FAIL zf%0d_Z got=%b exp=%b", v, Z, zz[v]); end
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_flight();
        test_random();
`ifdef ROTATE_PIPE_ZERO_FLAG_EN
        test_zero_flag();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rotate_pipe.md
ROTATE_PIPE -- requirements
Module: rotate_pipe

Interface
REQ-001 Parameter W, default 32: operand and result width; SHALL be a power of two, 8..64.
REQ-002 Parameter KW, default $clog2(W): shift-amount width; SHALL equal $clog2(W). STAGES = KW.
REQ-003 clk  in  1  rising-edge clock, the single clock of the block.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  1  A, B, K and right are valid this cycle.
REQ-006 in_ready  out  1  block accepts an operation this cycle.
REQ-007 A  in  W  upper funnel operand.
REQ-008 B  in  W  lower funnel operand.
REQ-009 K  in  KW  shift amount, 0..W-1.
REQ-010 right  in  1  1 = shift right, 0 = shift left.
REQ-011 out_valid  out  1  F holds a completed result.
REQ-012 out_ready  in  1  downstream accepts F this cycle.
REQ-013 F  out  W  funnel-shift result.
REQ-014 Z  out  1  result-is-zero flag; present only with ROTATE_PIPE_ZERO_FLAG_EN.

Function
REQ-015 Transfer SHALL occur on a rising edge with in_valid && in_ready (accept) or out_valid && out_ready (deliver).
REQ-016 Right: F SHALL be bits [W-1:0] of ({A,B} >> K). Left: F SHALL be bits [2W-1:W] of ({A,B} << K).
REQ-017 With A == B, F SHALL equal A rotated by K in the selected direction.
REQ-018 K = 0 SHALL give F = B (right) or F = A (left).
REQ-019 Pipeline SHALL have STAGES register stages; stage i (1-based) SHALL shift the 2W-bit word by 2^(i-1) when K bit i-1 is 1, otherwise pass it unchanged.
REQ-020 Each stage SHALL carry its own valid bit, the remaining K bits and right.
REQ-021 An op accepted on edge t SHALL present out_valid = 1 after edge t+STAGES-1, with no backpressure: latency STAGES cycles, throughput one op per cycle.
REQ-022 Stall = out_valid && !out_ready; while stalled every stage register SHALL hold and in_ready SHALL be 0.
REQ-023 in_ready SHALL equal !stall (combinational); in_valid with in_ready = 0 SHALL have no effect.
REQ-024 Bubbles (stages with valid = 0) SHALL advance while not stalled; empty stages SHALL NOT produce out_valid.
REQ-025 Results SHALL be delivered in accept order with none lost or duplicated, including across stalls of any length.
REQ-026 Accept and deliver on the same edge SHALL both take effect.
REQ-027 F SHALL hold stable while out_valid && !out_ready.

Reset
REQ-028 rst_n low SHALL immediately clear all stage valid bits, giving out_valid = 0, F = 0, and Z = 0 when present.
REQ-029 In-flight ops SHALL be discarded on reset, not completed.
REQ-030 in_ready SHALL be 1 during and after reset.
REQ-031 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-032 Macro ROTATE_PIPE_ZERO_FLAG_EN defined: port Z SHALL exist and equal (F == 0), registered alongside F with identical timing.
REQ-033 Macro ROTATE_PIPE_ZERO_FLAG_EN undefined: port Z and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (W = 32, STAGES = 5)
REQ-034 A=FFFF0000, B=0000FFFF, K=1 -> right F=00007FFF; left F=FFFE0000; each 5 cycles after accept.
REQ-035 Same A and B, K=31 -> right F=FFFE0000; left F=00007FFF. K=0 -> right F=0000FFFF; left F=FFFF0000.
REQ-036 A=B=12345678, K=4 -> right F=81234567; left F=23456781.
REQ-037 Six back-to-back ops with out_ready held low 3 cycles mid-stream -> in_ready = 0 during the stall; all six results delivered in order, none dropped; F stable while stalled.
REQ-038 rst_n pulsed low with 3 ops in flight -> out_valid = 0 immediately; none of the 3 results ever appears; a new op after release completes in 5 cycles.
REQ-039 With ROTATE_PIPE_ZERO_FLAG_EN defined: A=B=0, K=7 -> F=0, Z=1; then A=B=00000001, K=0 -> Z=0.
